// File: rtl/trap_control_unit.sv
// Trap control: exception/interrupt prioritisation and trap-entry/SRET FSM.
// Optional: define TRAP_VECTORED_MODE_EN to vector interrupts to base + 4*i.
module trap_control_unit #(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int NUM_IRQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [ILEN-1:0]    instruction,
   input  logic [XLEN-1:0]    pc,
   input  logic [XLEN-1:0]    mem_addr,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_enable,
   input  logic [XLEN-1:0]    stvec_base,
   output logic               exception_flag,
   output logic [XLEN-1:0]    scause,
   output logic [XLEN-1:0]    sepc,
   output logic [XLEN-1:0]    stval,
   output logic               redirect,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               in_handler,
   output logic               halted
);

   localparam logic [2:0] S_RUN      = 3'd0;
   localparam logic [2:0] S_REDIRECT = 3'd1;
   localparam logic [2:0] S_HANDLER  = 3'd2;
   localparam logic [2:0] S_RETURN   = 3'd3;
   localparam logic [2:0] S_HALT     = 3'd4;

   localparam logic [ILEN-1:0] ECALL  = ILEN'(32'h0000_0073);
   localparam logic [ILEN-1:0] EBREAK = ILEN'(32'h0010_0073);
   localparam logic [ILEN-1:0] SRET   = ILEN'(32'h1020_0073);

   logic [2:0]      r_state;
   logic            r_flag;
   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;
   logic            r_in_handler;
   logic            r_halted;
   logic [XLEN-1:0] r_scause;
   logic [XLEN-1:0] r_sepc;
   logic [XLEN-1:0] r_stval;

   logic [6:0]      w_op;
   logic [1:0]      w_f3;
   logic            w_legal;
   logic            w_sret;
   logic            w_illegal;
   logic            w_mis;
   logic [NUM_IRQ-1:0] w_pend;
   logic [3:0]      w_irq_idx;
   logic            w_irq_hit;
   logic            w_sync;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_tval;
   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_vec_pc;

   assign w_op   = instruction[6:0];
   assign w_f3   = instruction[13:12];
   assign w_sret = (instruction == SRET);
   assign w_base = stvec_base & ~XLEN'(3);

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         7'b0000011, 7'b0100011, 7'b0010011,
         7'b0011011, 7'b0110011, 7'b0111011,
         7'b0110111, 7'b0010111, 7'b1101111,
         7'b1100111, 7'b1100011, 7'b1110011: w_legal = 1'b1;
         default:                            w_legal = 1'b0;
      endcase
   end

   // SRET is only legal inside the handler; HANDLER checks it first.
   assign w_illegal = !w_legal || w_sret;

   always_comb begin
      w_mis = 1'b0;
      case (w_f3)
         2'b00:   w_mis = 1'b0;
         2'b01:   w_mis = mem_addr[0];
         2'b10:   w_mis = |mem_addr[1:0];
         default: w_mis = |mem_addr[2:0];
      endcase
   end

   assign w_pend    = irq & irq_enable;
   assign w_irq_hit = |w_pend;

   always_comb begin
      w_irq_idx = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[i]) w_irq_idx = 4'(i);
      end
   end

   always_comb begin
      w_sync  = 1'b1;
      w_cause = '0;
      w_tval  = '0;
      if (|pc[1:0]) begin
         w_cause = XLEN'(0);
         w_tval  = pc;
      end else if (w_illegal) begin
         w_cause = XLEN'(2);
         w_tval  = XLEN'(instruction);
      end else if (instruction == EBREAK) begin
         w_cause = XLEN'(3);
         w_tval  = pc;
      end else if (instruction == ECALL) begin
         w_cause = XLEN'(9);
      end else if (w_op == 7'b0000011 && w_mis) begin
         w_cause = XLEN'(4);
         w_tval  = mem_addr;
      end else if (w_op == 7'b0100011 && w_mis) begin
         w_cause = XLEN'(6);
         w_tval  = mem_addr;
      end else begin
         w_sync  = 1'b0;
      end
   end

`ifdef TRAP_VECTORED_MODE_EN
   assign w_vec_pc = r_scause[XLEN-1]
                   ? w_base + XLEN'({r_scause[3:0], 2'b00})
                   : w_base;
`else
   assign w_vec_pc = w_base;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_RUN;
         r_flag        <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_in_handler  <= 1'b0;
         r_halted      <= 1'b0;
         r_scause      <= '0;
         r_sepc        <= '0;
         r_stval       <= '0;
      end else begin
         r_flag     <= 1'b0;
         r_redirect <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (instr_valid && (w_irq_hit || w_sync)) begin
                  r_state <= S_REDIRECT;
                  r_flag  <= 1'b1;
                  r_sepc  <= pc;
                  if (w_irq_hit) begin
                     r_scause <= {1'b1, {(XLEN-5){1'b0}}, w_irq_idx};
                     r_stval  <= '0;
                  end else begin
                     r_scause <= w_cause;
                     r_stval  <= w_tval;
                  end
               end
            end
            S_REDIRECT: begin
               r_state       <= S_HANDLER;
               r_redirect    <= 1'b1;
               r_redirect_pc <= w_vec_pc;
               r_in_handler  <= 1'b1;
            end
            S_HANDLER: begin
               if (instr_valid && w_sret) begin
                  r_state      <= S_RETURN;
                  r_in_handler <= 1'b0;
               end else if (instr_valid && w_sync) begin
                  r_state      <= S_HALT;
                  r_in_handler <= 1'b0;
                  r_halted     <= 1'b1;
               end
            end
            S_RETURN: begin
               r_state       <= S_RUN;
               r_redirect    <= 1'b1;
               r_redirect_pc <= r_sepc;
            end
            default: begin
               r_state  <= S_HALT;
               r_halted <= 1'b1;
            end
         endcase
      end
   end

   assign exception_flag = r_flag;
   assign scause         = r_scause;
   assign sepc           = r_sepc;
   assign stval          = r_stval;
   assign redirect       = r_redirect;
   assign redirect_pc    = r_redirect_pc;
   assign in_handler     = r_in_handler;
   assign halted         = r_halted;

endmodule

// File: tb/tb_trap_control_unit.sv
// Directed bench for trap_control_unit: causes, priority, FSM and reset.
module tb_trap_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic [63:0] pc = '0;
   logic [63:0] mem_addr = '0;
   logic [3:0]  irq = '0;
   logic [3:0]  irq_enable = '0;
   logic [63:0] stvec_base = 64'h803;
   logic        exception_flag;
   logic [63:0] scause;
   logic [63:0] sepc;
   logic [63:0] stval;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        in_handler;
   logic        halted;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] ADD   = 32'h0000_0033;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] EBRK  = 32'h0010_0073;
   localparam logic [31:0] SRET  = 32'h1020_0073;
   localparam logic [31:0] BAD   = 32'hFE00_007F;

   trap_control_unit #(.XLEN(64), .ILEN(32), .NUM_IRQ(4)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid),
      .instruction(instruction), .pc(pc), .mem_addr(mem_addr),
      .irq(irq), .irq_enable(irq_enable), .stvec_base(stvec_base),
      .exception_flag(exception_flag), .scause(scause), .sepc(sepc),
      .stval(stval), .redirect(redirect), .redirect_pc(redirect_pc),
      .in_handler(in_handler), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i,
                        input logic [63:0] p, input logic [63:0] a);
      instr_valid = v;
      instruction = i;
      pc          = p;
      mem_addr    = a;
   endtask

   // From the cycle after trap entry: redirect, handler, SRET, return.
   task automatic run_return();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      cyc();
      drive(1'b1, SRET, 64'h900, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({exception_flag, redirect, in_handler, halted} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000",
                  {exception_flag, redirect, in_handler, halted});
      end
      checks++;
      if ({scause, sepc, stval, redirect_pc} !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h %h %h %h want 0",
                  scause, sepc, stval, redirect_pc);
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_add();
      drive(1'b1, ADD, 64'h10, 64'h0);
      cyc();
      cyc();
      checks++;
      if ({exception_flag, redirect, in_handler} !== 3'b000) begin
         errors++;
         $display("FAIL add_clean: got %b want 000",
                  {exception_flag, redirect, in_handler});
      end
      drive(1'b0, ADD, 64'h0, 64'h0);
   endtask

   task automatic test_illegal();
      drive(1'b1, BAD, 64'h20, 64'h0);
      cyc();
      checks++;
      if (exception_flag !== 1'b1 || scause !== 64'd2) begin
         errors++;
         $display("FAIL ill_flag: got %b/%h want 1/2", exception_flag, scause);
      end
      checks++;
      if (sepc !== 64'h20 || stval !== 64'hFE00007F) begin
         errors++;
         $display("FAIL ill_epc_tval: got %h/%h want 20/fe00007f", sepc, stval);
      end
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      checks++;
      if (exception_flag !== 1'b0 || redirect !== 1'b1 || redirect_pc !== 64'h800) begin
         errors++;
         $display("FAIL ill_redirect: got %b/%b/%h want 0/1/800",
                  exception_flag, redirect, redirect_pc);
      end
      cyc();
      checks++;
      if (redirect !== 1'b0 || in_handler !== 1'b1) begin
         errors++;
         $display("FAIL ill_handler: got %b/%b want 0/1", redirect, in_handler);
      end
      drive(1'b1, SRET, 64'h900, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== 64'h20 || in_handler !== 1'b0) begin
         errors++;
         $display("FAIL ill_return: got %b/%h/%b want 1/20/0",
                  redirect, redirect_pc, in_handler);
      end
      cyc();
   endtask

   task automatic test_ldst();
      drive(1'b1, 32'h0000_2003, 64'h40, 64'h31);
      cyc();
      checks++;
      if (scause !== 64'd4 || stval !== 64'h31 || sepc !== 64'h40) begin
         errors++;
         $display("FAIL lw_mis: got %h/%h/%h want 4/31/40", scause, stval, sepc);
      end
      run_return();
      drive(1'b1, 32'h0000_0003, 64'h44, 64'h31);
      cyc();
      checks++;
      if (exception_flag !== 1'b0) begin
         errors++;
         $display("FAIL lb_ok: got %b want 0", exception_flag);
      end
      drive(1'b1, 32'h0000_1023, 64'h48, 64'h46);
      cyc();
      checks++;
      if (exception_flag !== 1'b0) begin
         errors++;
         $display("FAIL sh_ok: got %b want 0", exception_flag);
      end
      drive(1'b1, 32'h0000_3023, 64'h4C, 64'h44);
      cyc();
      checks++;
      if (exception_flag !== 1'b1 || scause !== 64'd6 || stval !== 64'h44) begin
         errors++;
         $display("FAIL sd_mis: got %b/%h/%h want 1/6/44",
                  exception_flag, scause, stval);
      end
      run_return();
   endtask

   task automatic test_sync_causes();
      drive(1'b1, ADD, 64'h22, 64'h0);
      cyc();
      checks++;
      if (scause !== 64'd0 || stval !== 64'h22 || exception_flag !== 1'b1) begin
         errors++;
         $display("FAIL fetch_mis: got %b/%h/%h want 1/0/22",
                  exception_flag, scause, stval);
      end
      run_return();
      drive(1'b1, EBRK, 64'h60, 64'h0);
      cyc();
      checks++;
      if (scause !== 64'd3 || stval !== 64'h60) begin
         errors++;
         $display("FAIL ebreak: got %h/%h want 3/60", scause, stval);
      end
      run_return();
      drive(1'b1, SRET, 64'h64, 64'h0);
      cyc();
      checks++;
      if (scause !== 64'd2 || stval !== 64'h10200073) begin
         errors++;
         $display("FAIL sret_run: got %h/%h want 2/10200073", scause, stval);
      end
      run_return();
   endtask

   task automatic test_irq();
      logic [63:0] exp_pc;
`ifdef TRAP_VECTORED_MODE_EN
      exp_pc = 64'h804;
`else
      exp_pc = 64'h800;
`endif
      irq = 4'b0100;
      irq_enable = 4'b0011;
      drive(1'b1, ADD, 64'h70, 64'h0);
      cyc();
      checks++;
      if (exception_flag !== 1'b0) begin
         errors++;
         $display("FAIL irq_masked: got %b want 0", exception_flag);
      end
      irq = 4'b0110;
      irq_enable = 4'b1111;
      drive(1'b1, BAD, 64'h74, 64'h0);
      cyc();
      checks++;
      if (scause !== 64'h8000_0000_0000_0001 || stval !== 64'h0 || sepc !== 64'h74) begin
         errors++;
         $display("FAIL irq_cause: got %h/%h/%h want 8000000000000001/0/74",
                  scause, stval, sepc);
      end
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== exp_pc) begin
         errors++;
         $display("FAIL irq_vector: got %b/%h want 1/%h", redirect, redirect_pc, exp_pc);
      end
      drive(1'b1, ADD, 64'h800, 64'h0);
      cyc();
      cyc();
      checks++;
      if (exception_flag !== 1'b0 || in_handler !== 1'b1 || scause[63] !== 1'b1) begin
         errors++;
         $display("FAIL irq_in_handler: got %b/%b want 0/1", exception_flag, in_handler);
      end
      irq = 4'b0000;
      drive(1'b1, SRET, 64'h900, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== 64'h74) begin
         errors++;
         $display("FAIL irq_return: got %b/%h want 1/74", redirect, redirect_pc);
      end
      cyc();
   endtask

   task automatic test_ecall_halt();
      drive(1'b1, ECALL, 64'h50, 64'h0);
      cyc();
      checks++;
      if (scause !== 64'd9 || stval !== 64'h0 || sepc !== 64'h50) begin
         errors++;
         $display("FAIL ecall: got %h/%h/%h want 9/0/50", scause, stval, sepc);
      end
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      cyc();
      drive(1'b1, SRET, 64'h900, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      checks++;
      if (redirect !== 1'b1 || redirect_pc !== 64'h50 || in_handler !== 1'b0) begin
         errors++;
         $display("FAIL ecall_return: got %b/%h/%b want 1/50/0",
                  redirect, redirect_pc, in_handler);
      end
      cyc();
      drive(1'b1, ECALL, 64'h50, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      cyc();
      drive(1'b1, BAD, 64'h808, 64'h0);
      cyc();
      checks++;
      if (halted !== 1'b1 || in_handler !== 1'b0) begin
         errors++;
         $display("FAIL double_fault: got %b/%b want 1/0", halted, in_handler);
      end
      checks++;
      if (sepc !== 64'h50 || scause !== 64'd9 || stval !== 64'h0) begin
         errors++;
         $display("FAIL halt_keep: got %h/%h/%h want 50/9/0", sepc, scause, stval);
      end
      drive(1'b1, ADD, 64'h10, 64'h0);
      cyc();
      cyc();
      checks++;
      if (halted !== 1'b1 || exception_flag !== 1'b0 || redirect !== 1'b0) begin
         errors++;
         $display("FAIL halt_stuck: got %b/%b/%b want 1/0/0",
                  halted, exception_flag, redirect);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      drive(1'b1, ECALL, 64'h58, 64'h0);
      cyc();
      drive(1'b0, ADD, 64'h0, 64'h0);
      cyc();
      cyc();
      checks++;
      if (in_handler !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_handler: got %b want 1", in_handler);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({exception_flag, redirect, in_handler, halted} !== 4'b0 ||
          {scause, sepc, stval, redirect_pc} !== '0) begin
         errors++;
         $display("FAIL async_reset: got %b %h %h want all 0",
                  {exception_flag, redirect, in_handler, halted}, scause, sepc);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, ADD, 64'h10, 64'h0);
      cyc();
      cyc();
      checks++;
      if ({exception_flag, redirect, in_handler, halted} !== 4'b0) begin
         errors++;
         $display("FAIL post_reset_add: got %b want 0000",
                  {exception_flag, redirect, in_handler, halted});
      end
      drive(1'b0, ADD, 64'h0, 64'h0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_illegal();
      test_ldst();
      test_sync_causes();
      test_irq();
      test_ecall_halt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
